aes_inv_mix_columns_iter: RTL and testbench

Iterative AES InvMixColumns engine for the decryption datapath: takes a 128-bit state over a valid/ready handshake and applies the inverse column mix (matrix 0e 0b 0d 09, circulant) over GF(2^8) mod x^8+x^4+x^3+x+1. It processes LANES columns per cycle and returns the result over a second valid/ready handshake. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round and mirrors the forward column-mix logic.

---
 rtl/aes_inv_mix_columns_iter.sv | 159 +++++++++++++++
 tb/tb_aes_inv_mix_columns_iter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_mix_columns_iter.sv
// Iterative AES InvMixColumns engine: accepts a 128-bit state, transforms LANES
// columns per busy cycle in place, then holds the result until downstream accepts it.
module aes_inv_mix_columns_iter #(
  parameter int unsigned LANES = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] data_o
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned COL_W  = 32;
  localparam int unsigned NCOLS  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned BASE_W = 7;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NCOLS - LANES);
  localparam logic [CNT_W-1:0] COL_STEP = CNT_W'(LANES);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("aes_inv_mix_columns_iter: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   busy_data;

  logic [CNT_W-1:0]    lane_idx  [LANES];
  logic [BASE_W-1:0]   lane_base [LANES];
  logic [COL_W-1:0]    lane_in   [LANES];
  logic [COL_W-1:0]    lane_out  [LANES];
  logic [DATA_W-1:0]   mask_acc  [LANES+1];
  logic [DATA_W-1:0]   val_acc   [LANES+1];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // One output row; the other rows are the same coefficients rotated.
  function automatic logic [7:0] inv_row(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3);
    return mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
  endfunction

  function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] c);
    logic [7:0] b0, b1, b2, b3;
    b0 = c[31:24];
    b1 = c[23:16];
    b2 = c[15:8];
    b3 = c[7:0];
    return {inv_row(b0, b1, b2, b3), inv_row(b1, b2, b3, b0),
            inv_row(b2, b3, b0, b1), inv_row(b3, b0, b1, b2)};
  endfunction

  assign mask_acc[0] = '0;
  assign val_acc[0]  = '0;

  // Column k sits at bit offset 32*(3-k); for 2-bit k, 3-k is simply ~k.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l]   = col_q + CNT_W'(l);
    assign lane_base[l]  = {~lane_idx[l], 5'b00000};
    assign lane_in[l]    = COL_W'(data_q >> lane_base[l]);
    assign lane_out[l]   = inv_mix_col(lane_in[l]);
    assign mask_acc[l+1] = mask_acc[l] | ({{(DATA_W-COL_W){1'b0}}, {COL_W{1'b1}}} << lane_base[l]);
    assign val_acc[l+1]  = val_acc[l]  | ({{(DATA_W-COL_W){1'b0}}, lane_out[l]} << lane_base[l]);
  end

  assign busy_data = (data_q & ~mask_acc[LANES]) | val_acc[LANES];

  // Next-state and datapath-load decode.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          data_d  = data_i;
          col_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        data_d = busy_data;
        col_d  = col_q + COL_STEP;
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_o <= (state_d == IDLE);
      valid_o <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      col_q  <= '0;
      data_q <= '0;
    end else begin
      col_q  <= col_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_aes_inv_mix_columns_iter.sv
// Bench for aes_inv_mix_columns_iter: one instance per legal LANES value, a shared
// expected-result queue, table vectors, reset/backpressure sequences and a round trip.
module tb_aes_inv_mix_columns_iter;

  localparam int NI = 3;
  localparam logic [127:0] V1I = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1O = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2I = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_01010101;
  localparam logic [127:0] V2O = 128'hd4d4d4d5_2d26314c_db135345_01010101;
  localparam logic [127:0] VFF = {16{8'hff}};
  localparam logic [127:0] V80 = {16{8'h80}};

  typedef struct {
    int           k;
    logic [127:0] d;
  } exp_t;

  typedef struct {
    int           k;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  logic         clk = 1'b0;
  logic         nreset = 1'b1;
  logic         valid_in  [NI];
  logic         ready_out [NI];
  logic         valid_out [NI];
  logic         ready_in  [NI];
  logic [127:0] data_in   [NI];
  logic [127:0] data_out  [NI];

  exp_t exp_q[$];
  int   nchk = 0;
  int   npass = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  aes_inv_mix_columns_iter #(.LANES(1)) u_l1 (
    .clk(clk), .nreset(nreset), .valid_i(valid_in[0]), .ready_o(ready_out[0]),
    .data_i(data_in[0]), .valid_o(valid_out[0]), .ready_i(ready_in[0]), .data_o(data_out[0]));
  aes_inv_mix_columns_iter #(.LANES(2)) u_l2 (
    .clk(clk), .nreset(nreset), .valid_i(valid_in[1]), .ready_o(ready_out[1]),
    .data_i(data_in[1]), .valid_o(valid_out[1]), .ready_i(ready_in[1]), .data_o(data_out[1]));
  aes_inv_mix_columns_iter #(.LANES(4)) u_l4 (
    .clk(clk), .nreset(nreset), .valid_i(valid_in[2]), .ready_o(ready_out[2]),
    .data_i(data_in[2]), .valid_o(valid_out[2]), .ready_i(ready_in[2]), .data_o(data_out[2]));

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    nchk++;
    if (got === want) npass++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  // Generic shift-and-add GF(2^8) multiply, independent of the xtime chains in the design.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Forward MixColumns model (circulant 02 03 01 01).
  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [7:0]   cf [4];
    logic [7:0]   b  [4];
    logic [7:0]   o;
    logic [127:0] r = '0;
    cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) b[j] = s[127 - 32*c - 8*j -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o = o ^ gmul(cf[(j - rr + 4) % 4], b[j]);
        r[127 - 32*c - 8*rr -: 8] = o;
      end
    end
    return r;
  endfunction

  // Output scoreboard: a result leaves whenever valid and ready meet at the next edge.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (nreset && valid_out[k] && ready_in[k]) begin
        if (exp_q.size() == 0) begin
          nchk++;
          $display("FAIL out_unexpected inst=%0d got=%h want=none", k, data_out[k]);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("out_inst_l%0d", 1 << k), 128'(k), 128'(e.k));
          check($sformatf("out_data_l%0d", 1 << k), data_out[k], e.d);
        end
      end
    end
  end

  task automatic send(input int k, input logic [127:0] din, input logic [127:0] dout);
    int lat;
    int w;
    w = 0;
    while (!ready_out[k] && w < 20) begin @(posedge clk); #1; w++; end
    if (!ready_out[k]) begin
      nchk++;
      $display("FAIL ready_timeout inst=%0d got=0 want=1", k);
      return;
    end
    data_in[k] = din;
    valid_in[k] = 1'b1;
    exp_q.push_back('{k, dout});
    @(posedge clk); #1;
    valid_in[k] = 1'b0;
    lat = 0;
    while (!valid_out[k] && lat < 20) begin @(posedge clk); #1; lat++; end
    check($sformatf("latency_l%0d", 1 << k), 128'(lat), 128'(4 >> k));
    w = 0;
    while (valid_out[k] && w < 20) begin @(posedge clk); #1; w++; end
  endtask

  task automatic round_trip(input int k, input int n);
    logic [127:0] d;
    logic         r;
    int           tries;
    int           first;
    int           last;
    first = 0;
    last = 0;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      data_in[k] = fwd_mix(d);
      valid_in[k] = 1'b1;
      exp_q.push_back('{k, d});
      tries = 0;
      do begin
        r = ready_out[k];
        @(posedge clk); #1;
        tries++;
      end while (!r && tries < 50);
      if (!r) begin
        nchk++;
        $display("FAIL accept_timeout inst=%0d got=0 want=1", k);
        break;
      end
      if (i == 0) first = cyc;
      last = cyc;
    end
    valid_in[k] = 1'b0;
    check($sformatf("throughput_l%0d", 1 << k), 128'(last - first),
          128'((n - 1) * ((4 >> k) + 2)));
    tries = 0;
    while (exp_q.size() != 0 && tries < 50) begin @(posedge clk); #1; tries++; end
    check($sformatf("drain_l%0d", 1 << k), 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    vec_t vt[$];
    logic seen;
    int   lat;

    for (int k = 0; k < NI; k++) begin
      valid_in[k] = 1'b0;
      ready_in[k] = 1'b1;
      data_in[k]  = '0;
    end

    // Asynchronous reset values
    #1 nreset = 1'b0;
    #2;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_valid_l%0d", 1 << k), 128'(valid_out[k]), 128'(0));
      check($sformatf("rst_ready_l%0d", 1 << k), 128'(ready_out[k]), 128'(1));
      check($sformatf("rst_data_l%0d", 1 << k), data_out[k], 128'(0));
    end
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk); #1;

    vt.push_back('{0, V1I, V1O});
    vt.push_back('{1, V2I, V2O});
    vt.push_back('{2, V2I, V2O});
    vt.push_back('{0, V2I, V2O});
    vt.push_back('{1, V1I, V1O});
    vt.push_back('{2, V1I, V1O});
    for (int k = 0; k < NI; k++) vt.push_back('{k, VFF, VFF});
    for (int k = 0; k < NI; k++) vt.push_back('{k, V80, V80});
    foreach (vt[i]) send(vt[i].k, vt[i].din, vt[i].dout);

    // Reset while BUSY drops the block
    data_in[0] = V1I;
    valid_in[0] = 1'b1;
    @(posedge clk); #1;
    valid_in[0] = 1'b0;
    @(posedge clk); #2;
    nreset = 1'b0;
    #1;
    check("midrst_valid", 128'(valid_out[0]), 128'(0));
    check("midrst_ready", 128'(ready_out[0]), 128'(1));
    check("midrst_data", data_out[0], 128'(0));
    @(posedge clk); #1 nreset = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen = seen | valid_out[0]; end
    check("midrst_no_output", 128'(seen), 128'(0));

    // Backpressure hold in DONE, valid_i asserted but ignored
    ready_in[1] = 1'b0;
    data_in[1] = V2I;
    valid_in[1] = 1'b1;
    exp_q.push_back('{1, V2O});
    @(posedge clk); #1;
    valid_in[1] = 1'b0;
    lat = 0;
    while (!valid_out[1] && lat < 20) begin @(posedge clk); #1; lat++; end
    check("bp_latency", 128'(lat), 128'(2));
    for (int i = 0; i < 10; i++) begin
      data_in[1] = {$urandom, $urandom, $urandom, $urandom};
      valid_in[1] = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_hold", 128'(valid_out[1]), 128'(1));
      check("bp_ready_low", 128'(ready_out[1]), 128'(0));
      check("bp_data_hold", data_out[1], V2O);
    end
    valid_in[1] = 1'b0;
    ready_in[1] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 128'(ready_out[1]), 128'(1));
    check("bp_release_valid", 128'(valid_out[1]), 128'(0));
    repeat (6) @(posedge clk);
    #1;

    // Forward model then this block must give back the original state
    round_trip(0, 334);
    round_trip(1, 333);
    round_trip(2, 333);

    repeat (4) @(posedge clk);
    check("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
